// File: rtl/output_flow_handler.sv
// Transmit-side link stage: credit-throttled flit launch with a two-line phase
// announce (P/N inverted together once per flit) and toggle-based credit return.
module output_flow_handler #(
    parameter int DATA_WIDTH   = 32,
    parameter int CREDITS      = 4,
    parameter int CREDIT_WIDTH = 3
) (
    input  logic                    clka,
    input  logic                    rsta,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   link_data,
    output logic                    diff_pair_p,
    output logic                    diff_pair_n,
    input  logic                    credit_toggle,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic [1:0]              link_state,
    output logic                    credit_error
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_STALL  = 2'b10
    } link_state_t;

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX  = CREDIT_WIDTH'(CREDITS);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_ZERO = {CREDIT_WIDTH{1'b0}};
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE  = {{(CREDIT_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0]   link_data_r;
    logic                    phase_p_r;
    logic                    phase_n_r;
    logic [CREDIT_WIDTH-1:0] credit_count_r;
    logic [CREDIT_WIDTH-1:0] credit_count_nxt_s;
    logic                    credit_error_r;
    logic                    credit_error_nxt_s;
    logic                    toggle_r;
    logic                    ready_s;
    logic                    xfer_s;
    logic                    ret_s;
    link_state_t             state_r;
    link_state_t             state_nxt_s;

    // Ready depends only on registered credit state, never on in_valid.
    assign ready_s = (credit_count_r != CREDIT_ZERO) && !rsta;
    assign xfer_s  = in_valid && ready_s;
    assign ret_s   = credit_toggle ^ toggle_r;

    // Credit arithmetic: a simultaneous launch and return cancel out.
    always_comb begin
        credit_count_nxt_s = credit_count_r;
        credit_error_nxt_s = credit_error_r;
        if (xfer_s && !ret_s) begin
            credit_count_nxt_s = credit_count_r - CREDIT_ONE;
        end else if (!xfer_s && ret_s) begin
            if (credit_count_r == CREDIT_MAX) begin
                credit_error_nxt_s = 1'b1;
            end else begin
                credit_count_nxt_s = credit_count_r + CREDIT_ONE;
            end
        end else begin
            credit_count_nxt_s = credit_count_r;
        end
    end

    // Link state follows the post-edge credit count; ACTIVE is skipped when CREDITS is 1.
    always_comb begin
        state_nxt_s = state_r;
        if (credit_count_nxt_s == CREDIT_MAX) begin
            state_nxt_s = ST_IDLE;
        end else if (credit_count_nxt_s == CREDIT_ZERO) begin
            state_nxt_s = ST_STALL;
        end else begin
            state_nxt_s = ST_ACTIVE;
        end
    end

    // State, credit and phase registers; P/N always flip together.
    always_ff @(posedge clka) begin
        if (rsta) begin
            link_data_r    <= {DATA_WIDTH{1'b0}};
            phase_p_r      <= 1'b1;
            phase_n_r      <= 1'b0;
            credit_count_r <= CREDIT_MAX;
            credit_error_r <= 1'b0;
            toggle_r       <= 1'b0;
            state_r        <= ST_IDLE;
        end else begin
            toggle_r       <= credit_toggle;
            credit_count_r <= credit_count_nxt_s;
            credit_error_r <= credit_error_nxt_s;
            state_r        <= state_nxt_s;
            if (xfer_s) begin
                link_data_r <= in_data;
                phase_p_r   <= ~phase_p_r;
                phase_n_r   <= ~phase_n_r;
            end
        end
    end

    assign in_ready     = ready_s;
    assign link_data    = link_data_r;
    assign diff_pair_p  = phase_p_r;
    assign diff_pair_n  = phase_n_r;
    assign credit_count = credit_count_r;
    assign link_state   = state_r;
    assign credit_error = credit_error_r;

endmodule

// File: tb/tb_output_flow_handler.sv
// Directed bench for output_flow_handler with a minimal receiver phase model.
module tb_output_flow_handler;

    logic        clka;
    logic        rsta;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] link_data;
    logic        diff_pair_p;
    logic        diff_pair_n;
    logic        credit_toggle;
    logic [2:0]  credit_count;
    logic [1:0]  link_state;
    logic        credit_error;
    logic        rx_phase_r;
    logic        pipe_en_s;

    int n_compared;
    int n_mismatched;

    output_flow_handler #(.DATA_WIDTH(32), .CREDITS(4), .CREDIT_WIDTH(3)) dut (
        .clka          (clka),
        .rsta          (rsta),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .link_data     (link_data),
        .diff_pair_p   (diff_pair_p),
        .diff_pair_n   (diff_pair_n),
        .credit_toggle (credit_toggle),
        .credit_count  (credit_count),
        .link_state    (link_state),
        .credit_error  (credit_error)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Receiver phase tracker: enables when P differs from its last sample.
    always_ff @(posedge clka) begin
        rx_phase_r <= rsta ? 1'b1 : diff_pair_p;
    end
    assign pipe_en_s = diff_pair_p ^ rx_phase_r;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later; P/N complement checked every step.
    task automatic step();
        @(posedge clka);
        #1;
        check_eq("pn_complement", {63'd0, diff_pair_n}, {63'd0, ~diff_pair_p});
    endtask

    task automatic check_core(input string tag, input logic [31:0] data, input logic p,
                              input logic [2:0] cnt, input logic [1:0] st, input logic rdy);
        check_eq({tag, "_data"},  {32'd0, link_data},    {32'd0, data});
        check_eq({tag, "_p"},     {63'd0, diff_pair_p},  {63'd0, p});
        check_eq({tag, "_count"}, {61'd0, credit_count}, {61'd0, cnt});
        check_eq({tag, "_state"}, {62'd0, link_state},   {62'd0, st});
        check_eq({tag, "_ready"}, {63'd0, in_ready},     {63'd0, rdy});
    endtask

    initial begin
        n_compared    = 0;
        n_mismatched  = 0;
        rsta          = 1'b1;
        in_valid      = 1'b0;
        in_data       = 32'h0;
        credit_toggle = 1'b0;
        step();
        check_eq("rst_ready_low", {63'd0, in_ready}, 64'd0);
        step();
        rsta = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_core("idle", 32'h0, 1'b1, 3'd4, 2'b00, 1'b1);
        check_eq("idle_err", {63'd0, credit_error}, 64'd0);

        // Burst of four flits drains all credits.
        in_valid = 1'b1;
        in_data = 32'hA0; step(); check_core("b0", 32'hA0, 1'b0, 3'd3, 2'b01, 1'b1);
        in_data = 32'hA1; step(); check_core("b1", 32'hA1, 1'b1, 3'd2, 2'b01, 1'b1);
        in_data = 32'hA2; step(); check_core("b2", 32'hA2, 1'b0, 3'd1, 2'b01, 1'b1);
        in_data = 32'hA3; step(); check_core("b3", 32'hA3, 1'b1, 3'd0, 2'b10, 1'b0);

        // Stalled flit held until a credit comes back.
        in_data = 32'hB0; step(); check_core("stall", 32'hA3, 1'b1, 3'd0, 2'b10, 1'b0);
        credit_toggle = 1'b1; step(); check_core("ret1", 32'hA3, 1'b1, 3'd1, 2'b01, 1'b1);
        step(); check_core("b_acc", 32'hB0, 1'b0, 3'd0, 2'b10, 1'b0);
        in_valid = 1'b0;

        credit_toggle = 1'b0; step(); check_core("ret2", 32'hB0, 1'b0, 3'd1, 2'b01, 1'b1);
        credit_toggle = 1'b1; step(); check_core("ret3", 32'hB0, 1'b0, 3'd2, 2'b01, 1'b1);

        // Transfer and return on the same edge.
        in_valid = 1'b1; in_data = 32'hC0; credit_toggle = 1'b0;
        step(); check_core("simul", 32'hC0, 1'b1, 3'd2, 2'b01, 1'b1);
        in_valid = 1'b0;

        credit_toggle = 1'b1; step(); check_core("ret4", 32'hC0, 1'b1, 3'd3, 2'b01, 1'b1);
        credit_toggle = 1'b0; step(); check_core("ret5", 32'hC0, 1'b1, 3'd4, 2'b00, 1'b1);
        check_eq("err_before", {63'd0, credit_error}, 64'd0);

        // Excess return saturates and sets the sticky error.
        credit_toggle = 1'b1; step();
        check_eq("sat_count", {61'd0, credit_count}, 64'd4);
        check_eq("err_set", {63'd0, credit_error}, 64'd1);
        step(); step();
        check_eq("err_sticky", {63'd0, credit_error}, 64'd1);
        check_eq("sat_state", {62'd0, link_state}, 64'd0);
        rsta = 1'b1; step();
        check_eq("rst_ready", {63'd0, in_ready}, 64'd0);
        rsta = 1'b0; credit_toggle = 1'b0; step();
        check_eq("err_clear", {63'd0, credit_error}, 64'd0);
        check_eq("err_clr_cnt", {61'd0, credit_count}, 64'd4);

        // Reset mid-burst at one credit left.
        in_valid = 1'b1;
        in_data = 32'hD0; step();
        in_data = 32'hD1; step();
        in_data = 32'hD2; step(); check_core("d2", 32'hD2, 1'b0, 3'd1, 2'b01, 1'b1);
        rsta = 1'b1; step();
        check_eq("mr_p", {63'd0, diff_pair_p}, 64'd1);
        check_eq("mr_n", {63'd0, diff_pair_n}, 64'd0);
        check_eq("mr_count", {61'd0, credit_count}, 64'd4);
        check_eq("mr_state", {62'd0, link_state}, 64'd0);
        check_eq("mr_data", {32'd0, link_data}, 64'd0);
        check_eq("mr_pipe_en", {63'd0, pipe_en_s}, 64'd0);
        rsta = 1'b0; in_data = 32'hE0; step();
        in_valid = 1'b0;
        check_eq("e0_pipe_en", {63'd0, pipe_en_s}, 64'd1);
        check_core("e0", 32'hE0, 1'b0, 3'd3, 2'b01, 1'b1);
        step();
        check_eq("e0_pipe_off", {63'd0, pipe_en_s}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
